// File: rtl/montgomery_modexp_param.sv
// montgomery_modexp_param: left-to-right square-and-multiply X^E mod M driving an external Montgomery multiplier.
// Build option: define MODEXP_CONST_TIME_EN to square and multiply on every exponent bit regardless of E.
module montgomery_modexp_param #(
    parameter int WIDTH     = 512,
    parameter int EXP_WIDTH = 512
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [WIDTH-1:0]     in_rmodm,
    input  logic [WIDTH-1:0]     in_r2modm,
    input  logic [EXP_WIDTH-1:0] in_e,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 busy,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    output logic [WIDTH-1:0]     mul_m,
    input  logic                 mul_done,
    input  logic [WIDTH-1:0]     mul_result
);
    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(EXP_WIDTH - 1);
`ifdef MODEXP_CONST_TIME_EN
    localparam bit CONST_TIME = 1'b1;
`else
    localparam bit CONST_TIME = 1'b0;
`endif
    typedef enum logic [3:0] {
        IDLE, XT_REQ, XT_WAIT, SCAN, SQ_REQ, SQ_WAIT, MUL_REQ, MUL_WAIT, NEXT, OUT_REQ, OUT_WAIT, DONE
    } state_t;
    state_t               state, state_n;
    logic [WIDTH-1:0]     a, a_n, xt;
    logic [EXP_WIDTH-1:0] e;
    logic [IW-1:0]        idx, idx_n;
    logic                 bit_set;
    assign bit_set = e[idx];
    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end
    // Next state, accumulator/index updates and handshake outputs
    always_comb begin
        state_n   = state;
        a_n       = a;
        idx_n     = idx;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE) && (state != DONE);
        mul_start = (state == XT_REQ) || (state == SQ_REQ) || (state == MUL_REQ) || (state == OUT_REQ);
        case (state)
            IDLE: if (in_valid) begin
                state_n = XT_REQ;
                a_n     = in_rmodm;
                idx_n   = IDX_TOP;
            end
            XT_REQ:  state_n = XT_WAIT;
            XT_WAIT: if (mul_done) state_n = CONST_TIME ? SQ_REQ : SCAN;
            SCAN: begin
                if (bit_set)       state_n = SQ_REQ;
                else if (idx == 0) state_n = OUT_REQ;
                else               idx_n   = idx - 1'b1;
            end
            SQ_REQ:  state_n = SQ_WAIT;
            SQ_WAIT: if (mul_done) begin
                a_n     = mul_result;
                state_n = (CONST_TIME || bit_set) ? MUL_REQ : NEXT;
            end
            MUL_REQ:  state_n = MUL_WAIT;
            MUL_WAIT: if (mul_done) begin
                a_n     = bit_set ? mul_result : a;
                state_n = NEXT;
            end
            NEXT: begin
                if (idx == 0) state_n = OUT_REQ;
                else begin
                    idx_n   = idx - 1'b1;
                    state_n = SQ_REQ;
                end
            end
            OUT_REQ:  state_n = OUT_WAIT;
            OUT_WAIT: if (mul_done) state_n = DONE;
            DONE:     if (out_ready) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end
    // Operand capture, multiplier operand staging and result registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            a      <= '0;
            xt     <= '0;
            e      <= '0;
            idx    <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            mul_m  <= '0;
            result <= '0;
        end else begin
            a   <= a_n;
            idx <= idx_n;
            if (state == IDLE && in_valid) begin
                e     <= in_e;
                mul_m <= in_m;
                mul_a <= in_x;
                mul_b <= in_r2modm;
            end
            if (state == XT_WAIT && mul_done) xt <= mul_result;
            if (state == OUT_WAIT && mul_done) result <= mul_result;
            if (state_n == SQ_REQ || state_n == MUL_REQ || state_n == OUT_REQ) begin
                mul_a <= a_n;
                mul_b <= (state_n == SQ_REQ) ? a_n : (state_n == MUL_REQ) ? xt : WIDTH'(1);
            end
        end
    end
endmodule

// File: doc/montgomery_modexp_param.md
# montgomery_modexp_param

Parametrised left-to-right square-and-multiply modular exponentiator computing X^E mod M in the Montgomery domain. It succeeds the fixed 512-bit exponentiator with configurable operand and exponent widths, captured inputs, valid/ready handshakes on both sides, and an optional constant-time mode. Multiplications go to an external Montgomery multiplier of matching WIDTH through a start/done port, so one multiplier can be shared or swapped. The block sits between the RSA command front-end and the multiplier core.

## Interface
- WIDTH, 512: modulus/operand width; R = 2^WIDTH.
- EXP_WIDTH, 512: exponent width; scan index is $clog2(EXP_WIDTH) bits.
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  high only in IDLE.
- in_x, in_m, in_rmodm, in_r2modm  in  WIDTH  base, odd modulus, R mod M, R² mod M.
- in_e  in  EXP_WIDTH  exponent.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  X^E mod M.
- busy  out  1  high in every state except IDLE and DONE.
- mul_start  out  1  one-cycle multiplier request pulse.
- mul_a, mul_b  out  WIDTH  multiplier operands, registered.
- mul_m  out  WIDTH  captured modulus.
- mul_done  in  1  one-cycle pulse, result valid on the same cycle.
- mul_result  in  WIDTH  a·b·R⁻¹ mod M.

## Operation
- States: IDLE, XT_REQ, XT_WAIT, SCAN, SQ_REQ, SQ_WAIT, MUL_REQ, MUL_WAIT, NEXT, OUT_REQ, OUT_WAIT, DONE.
- IDLE: on in_valid && in_ready, capture all inputs. Set A <= in_rmodm, idx <= EXP_WIDTH-1, mul_a <= in_x, mul_b <= in_r2modm, then go to XT_REQ.
- XT_REQ: mul_start=1, then go to XT_WAIT. XT_WAIT: on mul_done, Xt <= mul_result, then go to SCAN.
- SCAN, one exponent bit per cycle:
  - e[idx]=1: go to SQ_REQ.
  - else if idx=0 (E=0): go to OUT_REQ.
  - else idx <= idx-1.
- SQ_REQ: operands A,A; mul_start=1. SQ_WAIT: on mul_done, A <= mul_result; go to MUL_REQ if e[idx]=1, else NEXT.
- MUL_REQ: operands A,Xt; pulse, then MUL_WAIT. MUL_WAIT: on mul_done, A <= mul_result, then go to NEXT.
- NEXT: if idx=0, go to OUT_REQ; else idx <= idx-1 and go to SQ_REQ.
- OUT_REQ: operands A,1; pulse. OUT_WAIT: on mul_done, result <= mul_result, then go to DONE.
- DONE: out_valid=1; on out_ready, go to IDLE.
- mul_a/mul_b are loaded on the edge entering each *_REQ state and held stable until the matching mul_done.
- mul_done outside *_WAIT states is ignored.
- Input ports are ignored outside IDLE; mid-run changes have no effect.
- E=0 yields 1 mod M (M=1 yields 0).

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, result 0, mul_start 0, mul_a/mul_b/mul_m 0, idx 0.
- Reset mid-operation aborts within one cycle. No further mul_start is issued; a late mul_done is ignored.
- Latency with multiplier latency L (mul_start to mul_done, L≥1), k = number of mul_start pulses, z = leading zeros of E:
  - non-CT: 1 + k·(L+1) + z + (number of NEXT visits) + 1 cycles from handshake to out_valid.
  - The bench checks exact cycle counts against a reference count, not this formula.
- in_ready stays low from the accept edge until the cycle after the out_valid/out_ready handshake.
- result holds its value after DONE until the next run writes it.

## Configuration
- MODEXP_CONST_TIME_EN defined:
  - SCAN is bypassed; XT_WAIT goes straight to SQ_REQ with idx=EXP_WIDTH-1.
  - SQ_WAIT always goes to MUL_REQ.
  - MUL_WAIT writes A only when e[idx]=1 and discards the result otherwise.
  - Multiplication count is always 2·EXP_WIDTH+2, independent of E.
- Undefined: leading-zero skip and multiply-only-on-one as described above.

## Test plan
- WIDTH=8, EXP_WIDTH=8, M=13, rmodm=9, r2modm=3, X=5, E=3 -> result=8, out_valid held until out_ready.
- Same setup, E=0 -> result=1, 2 mul_start pulses (non-CT); E=1 -> result=5.
- E=0b00001011, L=3 -> result=5^11 mod 13=8. Non-CT: 9 mul_start pulses. With MODEXP_CONST_TIME_EN: 18 pulses and identical result.
- out_ready held low 20 cycles in DONE, in_valid asserted -> no accept, result stable, in_ready=0 until handshake.
- resetn low during SQ_WAIT, then spurious mul_done -> state IDLE, in_ready=1, out_valid=0, no mul_start for 10 cycles.
- WIDTH=512 random X/E against a golden pow(x,e,m) for 50 vectors -> exact match; in_* toggled while busy -> no effect.
